// File: rtl/eth_pkt_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : eth_pkt_arbiter
// Brief    : Four-port packet arbiter for the ARM/Ethernet stream path.
//            Round-robin (PRIO=0) or fixed priority with port 0 highest
//            (PRIO=1). A grant is held for a whole packet. The output is
//            registered and backed by a one-entry skid buffer, so upstream
//            tready does not depend combinationally on downstream o_tready.
// Revision : 1.0 - initial release
// ============================================================================
module eth_pkt_arbiter #(
    parameter int WIDTH = 68,
    parameter int PRIO  = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,

    input  logic [WIDTH-1:0] i0_tdata,
    input  logic             i0_tlast,
    input  logic             i0_tvalid,
    output logic             i0_tready,

    input  logic [WIDTH-1:0] i1_tdata,
    input  logic             i1_tlast,
    input  logic             i1_tvalid,
    output logic             i1_tready,

    input  logic [WIDTH-1:0] i2_tdata,
    input  logic             i2_tlast,
    input  logic             i2_tvalid,
    output logic             i2_tready,

    input  logic [WIDTH-1:0] i3_tdata,
    input  logic             i3_tlast,
    input  logic             i3_tvalid,
    output logic             i3_tready,

    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,

    output logic [1:0]       grant,
    output logic             busy
);

    localparam int c_NPORTS = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // Port bundles gathered into arrays so the datapath can index by grant
    logic [WIDTH-1:0] w_tdata  [c_NPORTS];
    logic [c_NPORTS-1:0] w_tlast;
    logic [c_NPORTS-1:0] w_tvalid;
    logic [c_NPORTS-1:0] w_tready;

    // Arbitration state
    logic [1:0]       r_grant;
    logic [1:0]       r_last_grant;
    logic [1:0]       w_search_base;
    logic [1:0]       w_idx;
    logic [1:0]       w_sel;
    logic             w_found;

    // FSM strobes
    logic             w_start;
    logic             w_accept;
    logic             w_pkt_end;

    // Datapath
    logic [WIDTH-1:0] w_in_data;
    logic             w_in_last;
    logic             w_out_free;

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic             r_out_valid;

    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_last;
    logic             r_skid_valid;

    assign w_tdata[0] = i0_tdata;
    assign w_tdata[1] = i1_tdata;
    assign w_tdata[2] = i2_tdata;
    assign w_tdata[3] = i3_tdata;

    assign w_tlast    = {i3_tlast,  i2_tlast,  i1_tlast,  i0_tlast};
    assign w_tvalid   = {i3_tvalid, i2_tvalid, i1_tvalid, i0_tvalid};

    assign i0_tready  = w_tready[0];
    assign i1_tready  = w_tready[1];
    assign i2_tready  = w_tready[2];
    assign i3_tready  = w_tready[3];

    // Where the priority search begins: fixed at port 0, or one past the
    // port that finished the previous packet.
    generate
        if (PRIO != 0) begin : g_fixed_prio
            assign w_search_base = 2'd0;
        end else begin : g_round_robin
            assign w_search_base = r_last_grant + 2'd1;
        end
    endgenerate

    // Pick the first requesting port walking upward from the search base
    always_comb begin
        w_sel   = 2'd0;
        w_found = 1'b0;
        w_idx   = 2'd0;
        for (int k = 0; k < c_NPORTS; k++) begin
            w_idx = w_search_base + 2'(k);
            if (!w_found && w_tvalid[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake decode; clear overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        w_tready    = '0;
        w_start     = 1'b0;
        w_accept    = 1'b0;
        w_pkt_end   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_PASS;
                end
            end
            ST_PASS: begin
                // Only the owner may transfer, and only when a stalled
                // downstream still leaves room in the skid slot.
                w_tready[r_grant] = !r_skid_valid;
                w_accept          = w_tvalid[r_grant] && !r_skid_valid;
                if (w_accept && w_tlast[r_grant]) begin
                    w_pkt_end   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Grant latches at packet start; last_grant records the port that
    // completed a packet so round-robin rotates only at packet boundaries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant      <= 2'd0;
            r_last_grant <= 2'd3;
        end else if (clear) begin
            r_grant      <= 2'd0;
            r_last_grant <= 2'd3;
        end else begin
            if (w_start) begin
                r_grant <= w_sel;
            end
            if (w_pkt_end) begin
                r_last_grant <= r_grant;
            end
        end
    end

    assign w_in_data  = w_tdata[r_grant];
    assign w_in_last  = w_tlast[r_grant];
    assign w_out_free = !r_out_valid || o_tready;

    // Output register plus skid slot. The skid slot always drains first so
    // word order is preserved; a new word is parked there only when the
    // output register is holding a stalled word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (clear) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_last   <= r_skid_last;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_data   <= w_in_data;
                r_out_last   <= w_in_last;
                r_out_valid  <= 1'b1;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_data  <= w_in_data;
            r_skid_last  <= w_in_last;
            r_skid_valid <= 1'b1;
        end
    end

    assign o_tdata  = r_out_data;
    assign o_tlast  = r_out_last;
    assign o_tvalid = r_out_valid;
    assign grant    = r_grant;
    assign busy     = (r_state == ST_PASS);

endmodule
`default_nettype wire

// File: tb/tb_eth_pkt_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_eth_pkt_arbiter
// Brief    : Self-checking bench for eth_pkt_arbiter. One instance per
//            arbitration mode. Packets are queued per port; a packet-level
//            model predicts the serving order and output word stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_pkt_arbiter;

    localparam int          W      = 68;
    localparam logic [63:0] c_ONES = 64'h1111_1111_1111_1111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         clear;
    logic [W-1:0] tdata    [2][4];
    logic         tlast    [2][4];
    logic         tvalid   [2][4];
    logic         o_tready [2];

    logic [3:0]   a_rdy, b_rdy;
    logic [W-1:0] a_od, b_od;
    logic         a_ol, b_ol, a_ov, b_ov, a_bz, b_bz;
    logic [1:0]   a_gr, b_gr;

    eth_pkt_arbiter #(.WIDTH(W), .PRIO(0)) dut_rr (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .i0_tdata(tdata[0][0]), .i0_tlast(tlast[0][0]), .i0_tvalid(tvalid[0][0]), .i0_tready(a_rdy[0]),
        .i1_tdata(tdata[0][1]), .i1_tlast(tlast[0][1]), .i1_tvalid(tvalid[0][1]), .i1_tready(a_rdy[1]),
        .i2_tdata(tdata[0][2]), .i2_tlast(tlast[0][2]), .i2_tvalid(tvalid[0][2]), .i2_tready(a_rdy[2]),
        .i3_tdata(tdata[0][3]), .i3_tlast(tlast[0][3]), .i3_tvalid(tvalid[0][3]), .i3_tready(a_rdy[3]),
        .o_tdata(a_od), .o_tlast(a_ol), .o_tvalid(a_ov), .o_tready(o_tready[0]),
        .grant(a_gr), .busy(a_bz)
    );

    eth_pkt_arbiter #(.WIDTH(W), .PRIO(1)) dut_fp (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .i0_tdata(tdata[1][0]), .i0_tlast(tlast[1][0]), .i0_tvalid(tvalid[1][0]), .i0_tready(b_rdy[0]),
        .i1_tdata(tdata[1][1]), .i1_tlast(tlast[1][1]), .i1_tvalid(tvalid[1][1]), .i1_tready(b_rdy[1]),
        .i2_tdata(tdata[1][2]), .i2_tlast(tlast[1][2]), .i2_tvalid(tvalid[1][2]), .i2_tready(b_rdy[2]),
        .i3_tdata(tdata[1][3]), .i3_tlast(tlast[1][3]), .i3_tvalid(tvalid[1][3]), .i3_tready(b_rdy[3]),
        .o_tdata(b_od), .o_tlast(b_ol), .o_tvalid(b_ov), .o_tready(o_tready[1]),
        .grant(b_gr), .busy(b_bz)
    );

    int           n_vec = 0;
    int           n_err = 0;

    logic [W-1:0] drv_data [4][$];
    bit           drv_last [4][$];
    int           pkt_len  [4][$];
    bit           bub_now  [4];
    logic [W-1:0] exp_data [$];
    bit           exp_last [$];
    int           exp_port [$];
    int           acc_cyc  [$];
    int           model_last [2];
    int           first_pkt_port;
    bit           cfg_timing, cfg_rate, cfg_bubble, cfg_rand_ready;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic add_pkt(input int p, input int len, input bit pattern);
        logic [W-1:0] w;
        for (int i = 0; i < len; i++) begin
            if (pattern) begin
                w[63:0]  = c_ONES * 64'(i);
                w[67:64] = (i == len - 1) ? 4'h1 : 4'h0;
            end else begin
                w = {4'($urandom), $urandom, $urandom};
            end
            drv_data[p].push_back(w);
            drv_last[p].push_back(i == len - 1);
        end
        pkt_len[p].push_back(len);
    endtask

    // Packet-level model: every loaded port requests continuously, so each
    // decision picks the first port with packets left in search order.
    task automatic model_build(input int d, input bit fixed);
        int woff [4];
        int base, q, len;
        bit any;
        for (int p = 0; p < 4; p++) woff[p] = 0;
        any = 1'b1;
        while (any) begin
            any  = 1'b0;
            base = fixed ? 0 : (model_last[d] + 1) % 4;
            for (int k = 0; k < 4; k++) begin
                q = (base + k) % 4;
                if (!any && pkt_len[q].size() > 0) begin
                    any = 1'b1;
                    len = pkt_len[q].pop_front();
                    for (int i = 0; i < len; i++) begin
                        exp_data.push_back(drv_data[q][woff[q] + i]);
                        exp_last.push_back(drv_last[q][woff[q] + i]);
                    end
                    woff[q] += len;
                    exp_port.push_back(q);
                    model_last[d] = q;
                end
            end
        end
    endtask

    task automatic flush_all(input int d);
        for (int p = 0; p < 4; p++) begin
            drv_data[p].delete();
            drv_last[p].delete();
            pkt_len[p].delete();
            tvalid[d][p] = 1'b0;
            bub_now[p]   = 1'b0;
        end
        exp_data.delete();
        exp_last.delete();
        exp_port.delete();
        acc_cyc.delete();
    endtask

    task automatic drive(input int d);
        for (int p = 0; p < 4; p++) begin
            if (drv_data[p].size() > 0 && !bub_now[p]) begin
                tvalid[d][p] = 1'b1;
                tdata[d][p]  = drv_data[p][0];
                tlast[d][p]  = drv_last[p][0];
            end else begin
                tvalid[d][p] = 1'b0;
                tdata[d][p]  = {4'($urandom), $urandom, $urandom};
                tlast[d][p]  = 1'($urandom);
            end
        end
        o_tready[d] = cfg_rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Cycle engine: drives queued words, observes handshakes at the falling
    // edge, and checks the output stream against the model.
    task automatic run(input int d, input int max_cyc, input int stop_acc);
        int cyc, nacc, cur_port, last_tl, last_out;
        bit stall_prev, done;
        logic [W-1:0] stall_d, od;
        logic stall_l, ol, ov, bz;
        logic [3:0] rdy, allowed;
        logic [1:0] gr;
        bit acc [4];
        cyc = 0; nacc = 0; cur_port = -1; last_tl = -1; last_out = -1;
        stall_prev = 1'b0; done = 1'b0; stall_d = '0; stall_l = 1'b0;
        first_pkt_port = -1;
        acc_cyc.delete();
        for (int p = 0; p < 4; p++) bub_now[p] = 1'b0;
        drive(d);
        while (!done) begin
            @(negedge clk);
            cyc++;
            rdy = (d == 0) ? a_rdy : b_rdy;
            od  = (d == 0) ? a_od  : b_od;
            ol  = (d == 0) ? a_ol  : b_ol;
            ov  = (d == 0) ? a_ov  : b_ov;
            bz  = (d == 0) ? a_bz  : b_bz;
            gr  = (d == 0) ? a_gr  : b_gr;
            allowed = bz ? (4'b0001 << gr) : 4'b0000;
            n_vec++;
            if ((rdy & ~allowed) !== 4'b0000) begin
                n_err++;
                $display("FAIL tready_grant: cyc %0d tready=%b busy=%b grant=%0d, required ready only on granted port in PASS", cyc, rdy, bz, gr);
            end
            for (int p = 0; p < 4; p++) begin
                acc[p] = tvalid[d][p] && rdy[p];
                if (acc[p]) begin
                    nacc++;
                    if (cur_port == -1) begin
                        if (first_pkt_port == -1) first_pkt_port = p;
                        n_vec++;
                        if (exp_port.size() == 0 || p !== exp_port[0]) begin
                            n_err++;
                            $display("FAIL pkt_port: cyc %0d packet started on port %0d, required port %0d", cyc, p, (exp_port.size() > 0) ? exp_port[0] : -1);
                        end
                        if (exp_port.size() > 0) void'(exp_port.pop_front());
                        if (cfg_timing && last_tl >= 0) begin
                            n_vec++;
                            if (cyc - last_tl !== 2) begin
                                n_err++;
                                $display("FAIL turnaround: %0d cycles tlast-to-next-accept, required 2", cyc - last_tl);
                            end
                        end
                    end else begin
                        n_vec++;
                        if (p !== cur_port) begin
                            n_err++;
                            $display("FAIL contiguity: cyc %0d word from port %0d inside packet of port %0d", cyc, p, cur_port);
                        end
                    end
                    cur_port = drv_last[p][0] ? -1 : p;
                    if (drv_last[p][0]) last_tl = cyc;
                    if (cfg_timing) acc_cyc.push_back(cyc);
                end
            end
            if (ov && o_tready[d]) begin
                n_vec++;
                if (exp_data.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_word: cyc %0d got %h last=%b, required no word", cyc, od, ol);
                end else begin
                    if (od !== exp_data[0] || ol !== exp_last[0]) begin
                        n_err++;
                        $display("FAIL out_word: cyc %0d got %h last=%b, required %h last=%b", cyc, od, ol, exp_data[0], exp_last[0]);
                    end
                    void'(exp_data.pop_front());
                    void'(exp_last.pop_front());
                end
                if (cfg_timing) begin
                    n_vec++;
                    if (acc_cyc.size() == 0 || cyc !== acc_cyc[0] + 1) begin
                        n_err++;
                        $display("FAIL latency: output at cyc %0d, required accept cycle + 1 (%0d)", cyc, (acc_cyc.size() > 0) ? acc_cyc[0] + 1 : -1);
                    end
                    if (acc_cyc.size() > 0) void'(acc_cyc.pop_front());
                end
                if (cfg_rate && last_out >= 0) begin
                    n_vec++;
                    if (cyc - last_out !== 2) begin
                        n_err++;
                        $display("FAIL rate: %0d cycles between output words, required 2", cyc - last_out);
                    end
                end
                last_out = cyc;
            end
            if (stall_prev) begin
                n_vec++;
                if (ov !== 1'b1 || od !== stall_d || ol !== stall_l) begin
                    n_err++;
                    $display("FAIL stall_hold: cyc %0d valid=%b data=%h last=%b, required 1 %h %b", cyc, ov, od, ol, stall_d, stall_l);
                end
            end
            stall_prev = ov && !o_tready[d];
            stall_d    = od;
            stall_l    = ol;
            @(posedge clk);
            #1;
            for (int p = 0; p < 4; p++) begin
                if (acc[p]) begin
                    void'(drv_data[p].pop_front());
                    void'(drv_last[p].pop_front());
                    bub_now[p] = cfg_bubble;
                end else begin
                    bub_now[p] = 1'b0;
                end
            end
            drive(d);
            if (stop_acc > 0 && nacc >= stop_acc) begin
                done = 1'b1;
            end else if (drv_data[0].size() == 0 && drv_data[1].size() == 0 &&
                         drv_data[2].size() == 0 && drv_data[3].size() == 0 &&
                         exp_data.size() == 0) begin
                done = 1'b1;
            end else if (cyc >= max_cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL timeout: %0d cycles elapsed, %0d words still expected", cyc, exp_data.size());
                done = 1'b1;
            end
        end
        if (stop_acc == 0) begin
            n_vec++;
            if (exp_data.size() !== 0) begin
                n_err++;
                $display("FAIL drain: %0d words never emerged, required 0", exp_data.size());
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        clear   = 1'b0;
        for (int d = 0; d < 2; d++) begin
            o_tready[d] = 1'b1;
            for (int p = 0; p < 4; p++) begin
                tvalid[d][p] = 1'b0;
                tdata[d][p]  = '0;
                tlast[d][p]  = 1'b0;
            end
        end
        model_last[0] = 3;
        model_last[1] = 3;
        #2 reset_n = 1'b0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (c == 10) #2 reset_n = 1'b1;
            n_vec++;
            if ({a_ov, a_bz, a_rdy, a_ol, a_gr} !== 9'b0 || a_od !== '0) begin
                n_err++;
                $display("FAIL reset_rr: valid=%b busy=%b tready=%b last=%b grant=%0d data=%h, required all zero", a_ov, a_bz, a_rdy, a_ol, a_gr, a_od);
            end
            n_vec++;
            if ({b_ov, b_bz, b_rdy, b_ol, b_gr} !== 9'b0 || b_od !== '0) begin
                n_err++;
                $display("FAIL reset_fp: valid=%b busy=%b tready=%b last=%b grant=%0d data=%h, required all zero", b_ov, b_bz, b_rdy, b_ol, b_gr, b_od);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin;
        flush_all(0);
        cfg_timing = 1'b1; cfg_rate = 1'b0; cfg_bubble = 1'b0; cfg_rand_ready = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 4; p++) add_pkt(p, 10, 1'b1);
        add_pkt(1, $urandom_range(1, 6), 1'b0);
        add_pkt(3, $urandom_range(1, 6), 1'b0);
        model_build(0, 1'b0);
        run(0, 2000, 0);
    endtask

    task automatic test_fixed_priority;
        flush_all(1);
        cfg_timing = 1'b1; cfg_rate = 1'b0; cfg_bubble = 1'b0; cfg_rand_ready = 1'b0;
        for (int r = 0; r < 3; r++) add_pkt(0, $urandom_range(2, 6), 1'b0);
        for (int r = 0; r < 2; r++) add_pkt(2, $urandom_range(2, 6), 1'b0);
        model_build(1, 1'b1);
        run(1, 2000, 0);
    endtask

    task automatic test_backpressure;
        flush_all(0);
        cfg_timing = 1'b0; cfg_rate = 1'b0; cfg_bubble = 1'b1; cfg_rand_ready = 1'b1;
        for (int r = 0; r < 6; r++) add_pkt(2, $urandom_range(1, 8), 1'b0);
        model_build(0, 1'b0);
        run(0, 4000, 0);
    endtask

    task automatic test_single_word;
        flush_all(0);
        cfg_timing = 1'b1; cfg_rate = 1'b1; cfg_bubble = 1'b0; cfg_rand_ready = 1'b0;
        for (int r = 0; r < 8; r++) add_pkt(3, 1, 1'b0);
        model_build(0, 1'b0);
        run(0, 1000, 0);
    endtask

    task automatic test_mid_clear;
        flush_all(0);
        cfg_timing = 1'b1; cfg_rate = 1'b0; cfg_bubble = 1'b0; cfg_rand_ready = 1'b0;
        add_pkt(0, 3, 1'b0);
        model_build(0, 1'b0);
        run(0, 500, 0);
        flush_all(0);
        add_pkt(1, 10, 1'b1);
        model_build(0, 1'b0);
        run(0, 500, 4);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        flush_all(0);
        model_last[0] = 3;
        @(negedge clk);
        n_vec++;
        if (a_ov !== 1'b0 || a_bz !== 1'b0 || a_rdy !== 4'b0) begin
            n_err++;
            $display("FAIL clear_flush: valid=%b busy=%b tready=%b, required 0 0 0000", a_ov, a_bz, a_rdy);
        end
        @(posedge clk);
        #1;
        add_pkt(1, $urandom_range(1, 5), 1'b0);
        add_pkt(0, $urandom_range(1, 5), 1'b0);
        model_build(0, 1'b0);
        run(0, 500, 0);
        n_vec++;
        if (first_pkt_port !== 0) begin
            n_err++;
            $display("FAIL clear_restart: first port after clear %0d, required 0", first_pkt_port);
        end
    endtask

    initial begin
        cfg_timing = 1'b0; cfg_rate = 1'b0; cfg_bubble = 1'b0; cfg_rand_ready = 1'b0;
        first_pkt_port = -1;
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_backpressure();
        test_single_word();
        test_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_pkt_arbiter.md
ETH_PKT_ARBITER -- requirements
Module: eth_pkt_arbiter

Interface
REQ-001 Parameter WIDTH, default 68; word width per port, {tuser[3:0], tdata[63:0]} as carried on the ARM/Ethernet path.
REQ-002 Parameter PRIO, default 0; 0 = round-robin, 1 = fixed priority with port 0 highest.
REQ-003 clk  input  1  sole clock; all logic is rising-edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 clear  input  1  synchronous, active-high soft reset.
REQ-006 iN_tdata  input  WIDTH  port N data, N=0..3.
REQ-007 iN_tlast  input  1  port N end of packet.
REQ-008 iN_tvalid  input  1  port N word valid.
REQ-009 iN_tready  output  1  port N word accepted when tvalid & tready.
REQ-010 o_tdata  output  WIDTH  arbitrated data.
REQ-011 o_tlast  output  1  arbitrated end of packet.
REQ-012 o_tvalid  output  1  arbitrated word valid.
REQ-013 o_tready  input  1  downstream accept.
REQ-014 grant  output  2  index of the port currently owning the output.
REQ-015 busy  output  1  high while in state PASS.

Function
REQ-016 States: IDLE, PASS.
- IDLE: all iN_tready low.
- IDLE -> PASS on any iN_tvalid; grant registered on that edge.
REQ-017 Selection, PRIO=0: search starts at (last_grant+1) mod 4 and wraps; first valid port wins.
REQ-018 Selection, PRIO=1: lowest-indexed valid port wins.
REQ-019 PASS:
- Only the granted port's tready may be high; ungranted ports' tready low.
- Words pass in order, unmodified, tuser bits included.
REQ-020 PASS -> IDLE on the edge that accepts the granted port's word with tlast=1; last_grant updated to that port on the same edge.
REQ-021 Grant never changes mid-packet, whatever the other ports' tvalid.
REQ-022 Output path: one registered stage plus a one-entry skid buffer.
- Latency from input accept to o_tvalid: 1 cycle.
- Sustained throughput in PASS: 1 word/cycle.
REQ-023 Input tready in PASS = skid buffer empty; a word accepted while o_tready is low is held in the skid buffer.
REQ-024 o_tvalid, o_tdata and o_tlast hold stable while o_tvalid=1 and o_tready=0.
REQ-025 Packet turnaround: exactly one IDLE cycle between the accepted tlast of one packet and the first accept of the next packet.
REQ-026 Single-word packet (tvalid and tlast on first word): accepted in 1 PASS cycle; returns to IDLE.
REQ-027 Simultaneous requests in IDLE: one winner per REQ-017/018; the other requests remain pending with no loss.
REQ-028 clear, sampled high at a rising edge:
- Forces IDLE; empties the output stage and skid buffer; o_tvalid low next cycle.
- Sets last_grant=3, so port 0 is searched first next.
- A packet in flight is truncated without a tlast; this is accepted behaviour.
REQ-029 clear has priority over every state transition on the same edge.

Reset
REQ-030 While reset_n=0, asynchronously:
- State IDLE; last_grant=3; grant=0; busy=0.
- o_tvalid=0, o_tlast=0, o_tdata=0; all iN_tready=0; skid buffer empty.
REQ-031 First possible grant: first rising edge after reset_n is released.

Verification
REQ-032 Reset/idle: reset_n low 100 ns, no tvalid -> o_tvalid=0, busy=0 and all tready=0 throughout.
REQ-033 Round-robin, PRIO=0: all 4 ports each offer 10-word packets (words 0x1111...×i, last word tuser=1, data 0x9999...) -> output port order 0,1,2,3,0,…; each packet contiguous and intact; one idle cycle between packets.
REQ-034 Fixed priority, PRIO=1: ports 0 and 2 both continuously request -> only port 0 is served; port 2 is granted only after port 0 drops tvalid at a packet boundary.
REQ-035 Backpressure: o_tready toggled with a random pattern, input bubbles inserted after every word -> output sequence word-for-word identical to the input; no duplicate or dropped word; tdata stable while stalled.
REQ-036 Mid-packet clear: port 1 at word 4 of 10, pulse clear 1 cycle -> o_tvalid=0 next cycle; next simultaneous request from ports 0 and 1 granted to port 0.
REQ-037 Single-word packets: back-to-back single-word packets on port 3 -> output rate of one word per 2 cycles with tlast=1 on every word.
